// File: rtl/fp_div_if.sv
// rtl/fp_div_if.sv - start/done handshake and operand/result bundle for fp_div
//
// Purpose : groups the request, operand and result signals of the iterative
//           single-precision divider.
// Signals : start  - request, sampled only while the divider is idle
//           A, B   - dividend / divisor, IEEE-754 single
//           Y      - quotient, registered, holds the last result
//           busy   - high while an operation is in flight
//           done   - one-cycle pulse, Y/dbz valid from this cycle
//           dbz    - divide-by-zero flag, updated together with Y
// Modports: master drives start/A/B, slave (the divider) drives the results.
interface fp_div_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic        dbz;

  modport master (
    output start, A, B,
    input  Y, busy, done, dbz
  );

  modport slave (
    input  start, A, B,
    output Y, busy, done, dbz
  );
endinterface

// File: rtl/fp_div.sv
// rtl/fp_div.sv - iterative IEEE-754 single-precision divider, Y = A / B
//
// Purpose : restoring mantissa division, one quotient bit per clock, with a
//           fixed 27-edge start-to-done latency for every operand class.
//           Denormal inputs are flushed to zero; the result is truncated.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, aborts any operation
//           bus   - fp_div_if slave modport (start, A, B in; Y, busy, done,
//                   dbz out)
module fp_div (
  input  logic        clk,
  input  logic        rst_n,
  fp_div_if.slave     bus
);

  localparam int QBITS = 25;
  localparam int BIAS  = 127;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic                sign_q;
  logic                a_zero_q;
  logic                b_zero_q;
  logic signed [9:0]   e_q;
  logic [23:0]         mb_q;
  logic [QBITS-1:0]    r_q;
  logic [QBITS-1:0]    q_q;
  logic [4:0]          cnt_q;
  logic [31:0]         y_q;
  logic                busy_q;
  logic                done_q;
  logic                dbz_q;

  // One restoring-division step.
  logic                ge;
  logic [QBITS-1:0]    r_sub;
  logic [QBITS-1:0]    r_d;
  logic [QBITS-1:0]    q_d;

  // Normalisation / packing of the final result.
  logic signed [9:0]   exp_n;
  logic [22:0]         mant_n;
  logic [31:0]         y_d;
  logic                dbz_d;
  logic signed [9:0]   e_d;

  // R stays below 2*mb, so the shift never loses a set bit: after a
  // successful subtract R < mb < 2^24, otherwise R < mb already.
  always_comb begin
    ge    = (r_q >= {1'b0, mb_q});
    r_sub = ge ? (r_q - {1'b0, mb_q}) : r_q;
    r_d   = r_sub << 1;
    q_d   = {q_q[QBITS-2:0], ge};
  end

  always_comb begin
    e_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
          + 10'(BIAS);
  end

  always_comb begin
    y_d   = 32'h0;
    dbz_d = 1'b0;
    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one
    // left shift is needed to normalise.
    if (q_q[QBITS-1]) begin
      mant_n = q_q[23:1];
      exp_n  = e_q;
    end else begin
      mant_n = q_q[22:0];
      exp_n  = e_q - 10'sd1;
    end

    if (a_zero_q && b_zero_q) begin
      y_d   = 32'h7FC0_0000;
      dbz_d = 1'b1;
    end else if (b_zero_q) begin
      y_d   = {sign_q, 8'hFF, 23'h0};
      dbz_d = 1'b1;
    end else if (a_zero_q) begin
      y_d   = {sign_q, 31'h0};
    end else if (exp_n >= 10'sd255) begin
      y_d   = {sign_q, 8'hFF, 23'h0};
    end else if (exp_n <= 10'sd0) begin
      y_d   = {sign_q, 31'h0};
    end else begin
      y_d   = {sign_q, exp_n[7:0], mant_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      e_q      <= 10'sd0;
      mb_q     <= 24'h0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= 5'd0;
      y_q      <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          sign_q   <= a_q[31] ^ b_q[31];
          a_zero_q <= (a_q[30:23] == 8'h00);
          b_zero_q <= (b_q[30:23] == 8'h00);
          e_q      <= e_d;
          mb_q     <= {1'b1, b_q[22:0]};
          r_q      <= {2'b01, a_q[22:0]};
          q_q      <= '0;
          cnt_q    <= 5'd0;
          state_q  <= DIV;
        end
        DIV: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(QBITS - 1)) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          y_q     <= y_d;
          dbz_q   <= dbz_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - self-checking bench for fp_div
module tb_fp_div;

  logic clk;
  logic rst_n;
  fp_div_if bus ();

  fp_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        dbz;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact quotient floor(ma*2^24/mb) then normalise/pack.
  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    longint      ma, mb, q;
    logic [22:0] mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 && eb == 0) return {1'b1, 32'h7FC00000};
    if (eb == 0)            return {1'b1, s, 8'hFF, 23'h0};
    if (ea == 0)            return {1'b0, s, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * (64'sd1 << 24)) / mb;
    e  = ea - eb + 127;
    if (q >= (64'sd1 << 24)) begin
      mant = 23'((q >> 1) & 64'h7FFFFF);
    end else begin
      mant = 23'(q & 64'h7FFFFF);
      e    = e - 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], mant};
  endfunction

  // Start on edge 0, wait for done, then step through the DONE edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output logic d,
                       output int lat);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    y = bus.Y;
    d = bus.dbz;
    @(posedge clk);
    #1;
    check("busy_after_done", {31'h0, bus.busy}, 32'h0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) e = 8'h00;
    else e = 8'($urandom_range(1, 254));
    r[30:23] = e;
    return r;
  endfunction

  vec_t        vecs[8];
  logic [31:0] y;
  logic        d;
  int          lat;
  logic [32:0] m;
  int          extra_done;
  int          busy_bad;

  initial begin
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
    vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0};
    vecs[3] = '{32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000000, 32'h7FC00000, 1'b1};
    vecs[5] = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0};
    vecs[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0};
    vecs[7] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = 32'h0;
    bus.B = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_Y", bus.Y, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    check("reset_dbz", {31'h0, bus.dbz}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, y, d, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd27);
      check($sformatf("vec%0d_Y", i), y, vecs[i].y);
      check($sformatf("vec%0d_dbz", i), {31'h0, d}, {31'h0, vecs[i].dbz});
    end

    // Randomised operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      m  = model(ra, rb);
      do_op(ra, rb, y, d, lat);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd27);
      check($sformatf("rand%0d_Y(%h/%h)", i, ra, rb), y, m[31:0]);
      check($sformatf("rand%0d_dbz", i), {31'h0, d}, {31'h0, m[32]});
    end

    // start held high, operands changed while busy: first operands win,
    // busy stays high throughout, and no second done follows.
    @(negedge clk);
    bus.A = 32'h40C00000;
    bus.B = 32'h40000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.A = 32'h3F800000;
    bus.B = 32'h40400000;
    lat = 0;
    busy_bad = 0;
    while (!bus.done && lat < 60) begin
      if (!bus.busy) busy_bad++;
      @(posedge clk);
      lat++;
      #1;
    end
    bus.start = 1'b0;
    check("hold_latency", 32'(lat), 32'd27);
    check("hold_busy_low_count", 32'(busy_bad), 32'd0);
    check("hold_Y", bus.Y, 32'h40400000);
    extra_done = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.done) extra_done++;
    end
    check("hold_no_second_done", 32'(extra_done), 32'd0);

    // Back-to-back: start re-asserted the cycle after done.
    do_op(32'h40C00000, 32'h40000000, y, d, lat);
    check("b2b_first_Y", y, 32'h40400000);
    do_op(32'h3F800000, 32'h40400000, y, d, lat);
    check("b2b_second_latency", 32'(lat), 32'd27);
    check("b2b_second_Y", y, 32'h3EAAAAAA);

    // Asynchronous reset at edge 10 of an operation.
    @(negedge clk);
    bus.A = 32'h40A00000;
    bus.B = 32'h00000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_Y", bus.Y, 32'h0);
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    check("abort_dbz", {31'h0, bus.dbz}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h40C00000, 32'h40000000, y, d, lat);
    check("post_reset_latency", 32'(lat), 32'd27);
    check("post_reset_Y", y, 32'h40400000);
    check("post_reset_dbz", {31'h0, d}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
